alu_issue: RTL and testbench

Issue stage feeding the 64-bit `alu` block: decodes the control unit's 2-bit ALUOp plus funct3/funct7[5] into the 4-bit `alu_operation` code and selects the second operand (rs2 or immediate). Presents a registered operation/operand bundle to the ALU through a valid/ready handshake. A two-entry skid buffer allows full throughput with a registered `in_ready`. Sits between register-read/immediate-gen and the ALU in the EX stage.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_ctrl_decode.sv | 36 +++
 rtl/alu_issue.sv | 128 ++++++++++++
 tb/tb_alu_issue.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, ALUOp encodings and the issue bundle.
// Imported by the decoder and by the EX-stage issue logic.
package alu_pkg;

    localparam int ISSUE_XLEN = 64;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic [1:0] {
        AOP_MEM = 2'b00,
        AOP_BR  = 2'b01,
        AOP_R   = 2'b10,
        AOP_I   = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [3:0]            op;
        logic [ISSUE_XLEN-1:0] a;
        logic [ISSUE_XLEN-1:0] b;
        logic                  illegal;
    } issue_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: ALUOp/funct3/funct7[5] to 4-bit ALU opcode.
// Purely combinational so a single-cycle datapath can reuse it.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_b5,
    output logic [3:0] o_alu_operation,
    output logic       o_illegal
);

    always_comb begin
        o_alu_operation = ALU_AND;
        o_illegal       = 1'b0;
        unique case (i_alu_op)
            AOP_MEM: o_alu_operation = ALU_ADD;
            AOP_BR:  o_alu_operation = ALU_SUB;
            default: begin
                unique case (i_funct3)
                    F3_ADD: begin
                        // I-type has no SUBI, so bit 30 only matters for R-type
                        if (i_alu_op == AOP_R && i_funct7_b5)
                            o_alu_operation = ALU_SUB;
                        else
                            o_alu_operation = ALU_ADD;
                    end
                    F3_AND:  o_alu_operation = ALU_AND;
                    F3_OR:   o_alu_operation = ALU_OR;
                    default: o_illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: EX-stage issue into the ALU with a two-entry skid buffer.
// Output register plus skid register keep full rate with a registered in_ready.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_b5,
    input  logic            alu_src,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_operation,
    output logic [XLEN-1:0] input_data1,
    output logic [XLEN-1:0] input_data2,
    output logic            illegal
);

    occ_e       r_state;
    occ_e       w_state_nxt;
    logic       r_in_ready;
    issue_t     r_out;
    issue_t     r_skid;
    issue_t     w_new;
    logic [3:0] w_op;
    logic       w_ill;
    logic       w_acc;
    logic       w_drn;
    logic       w_out_from_in;
    logic       w_out_from_skid;
    logic       w_skid_load;

    alu_ctrl_decode u_dec (
        .i_alu_op        (alu_op),
        .i_funct3        (funct3),
        .i_funct7_b5     (funct7_b5),
        .o_alu_operation (w_op),
        .o_illegal       (w_ill)
    );

    assign w_new.op      = w_op;
    assign w_new.a       = ISSUE_XLEN'(rs1_data);
    assign w_new.b       = ISSUE_XLEN'(alu_src ? imm : rs2_data);
    assign w_new.illegal = w_ill;

    assign w_acc = in_valid && r_in_ready;
    assign w_drn = out_valid && out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_out_from_in   = 1'b0;
        w_out_from_skid = 1'b0;
        w_skid_load     = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt   = ST_ONE;
                    w_out_from_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_acc && w_drn) begin
                    w_out_from_in = 1'b1;
                end else if (w_acc) begin
                    w_state_nxt = ST_FULL;
                    w_skid_load = 1'b1;
                end else if (w_drn) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_drn) begin
                    w_state_nxt     = ST_ONE;
                    w_out_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // Flush discards both entries and any bundle offered this cycle
        if (flush) begin
            w_state_nxt     = ST_EMPTY;
            w_out_from_in   = 1'b0;
            w_out_from_skid = 1'b0;
            w_skid_load     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_out_from_in)
                r_out <= w_new;
            else if (w_out_from_skid)
                r_out <= r_skid;
            if (w_skid_load)
                r_skid <= w_new;
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = (r_state != ST_EMPTY);
    assign alu_operation = r_out.op;
    assign input_data1   = XLEN'(r_out.a);
    assign input_data2   = XLEN'(r_out.b);
    assign illegal       = r_out.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized and directed checks of alu_issue against a
// two-deep FIFO reference model with an independent decode table.
module tb_alu_issue;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            funct7_b5;
    logic            alu_src;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      alu_operation;
    logic [XLEN-1:0] input_data1;
    logic [XLEN-1:0] input_data2;
    logic            illegal;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            ill;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    alu_issue #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_op        (alu_op),
        .funct3        (funct3),
        .funct7_b5     (funct7_b5),
        .alu_src       (alu_src),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .imm           (imm),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_operation (alu_operation),
        .input_data1   (input_data1),
        .input_data2   (input_data2),
        .illegal       (illegal)
    );

    function automatic exp_t model(input logic [1:0] aop, input logic [2:0] f3,
                                   input logic b5, input logic src,
                                   input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input logic [XLEN-1:0] im);
        exp_t e;
        e.a   = a;
        e.b   = src ? im : b;
        e.ill = 1'b0;
        e.op  = 4'b0000;
        if (aop == 2'b00)      e.op = 4'b0010;
        else if (aop == 2'b01) e.op = 4'b0110;
        else if (f3 == 3'b000) e.op = (aop == 2'b10 && b5) ? 4'b0110 : 4'b0010;
        else if (f3 == 3'b111) e.op = 4'b0000;
        else if (f3 == 3'b110) e.op = 4'b0001;
        else                   e.ill = 1'b1;
        return e;
    endfunction

    // Drive at negedge, let the posedge transfer happen, update model, return at negedge
    task automatic drive(input logic v, input logic [1:0] aop, input logic [2:0] f3,
                         input logic b5, input logic src, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] im,
                         input logic ordy, input logic fl);
        exp_t e;
        int   sz;
        in_valid  = v;
        alu_op    = aop;
        funct3    = f3;
        funct7_b5 = b5;
        alu_src   = src;
        rs1_data  = a;
        rs2_data  = b;
        imm       = im;
        out_ready = ordy;
        flush     = fl;
        e  = model(aop, f3, b5, src, a, b, im);
        sz = q.size();
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (ordy && sz > 0) void'(q.pop_front());
            if (v && sz < 2) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drive_rand(input logic v, input logic ordy, input logic fl);
        drive(v, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              ordy, fl);
    endtask

    task automatic test_reset();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_tests++;
        if (alu_operation !== 4'b0000) begin n_fail++; $display("FAIL reset_op got %b want 0000", alu_operation); end
        n_tests++;
        if (input_data1 !== '0 || input_data2 !== '0)
            begin n_fail++; $display("FAIL reset_data got %h/%h want 0/0", input_data1, input_data2); end
        n_tests++;
        if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", illegal); end
    endtask

    task automatic test_rtype_add();
        drive(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 64'd3, 64'd4, 64'd77, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b want 1", out_valid); end
        n_tests++;
        if ({alu_operation, illegal} !== {4'b0010, 1'b0})
            begin n_fail++; $display("FAIL add_op got %b/%b want 0010/0", alu_operation, illegal); end
        n_tests++;
        if (input_data1 !== 64'd3 || input_data2 !== 64'd4)
            begin n_fail++; $display("FAIL add_data got %h/%h want 3/4", input_data1, input_data2); end
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got %b want 0", out_valid); end
    endtask

    task automatic test_decode_sweep();
        logic [1:0] t_aop [7] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
        logic [2:0] t_f3  [7] = '{3'b101, 3'b010, 3'b000, 3'b111, 3'b110, 3'b000, 3'b001};
        logic       t_b5  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] t_op  [7] = '{4'b0010, 4'b0110, 4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0000};
        logic       t_ill [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, t_aop[i], t_f3[i], t_b5[i], 1'b0, 64'(i), 64'(i + 10), '0, 1'b1, 1'b0);
            n_tests++;
            if (out_valid !== 1'b1 || alu_operation !== t_op[i] || illegal !== t_ill[i])
                $display("FAIL decode_%0d got v=%b op=%b ill=%b want v=1 op=%b ill=%b",
                         i, out_valid, alu_operation, illegal, t_op[i], t_ill[i]);
            if (out_valid !== 1'b1 || alu_operation !== t_op[i] || illegal !== t_ill[i])
                n_fail++;
        end
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_addi();
        drive(1'b1, 2'b11, 3'b000, 1'b0, 1'b1, 64'd5, 64'd9, '1, 1'b1, 1'b0);
        n_tests++;
        if (input_data2 !== 64'hFFFF_FFFF_FFFF_FFFF || input_data1 !== 64'd5 || alu_operation !== 4'b0010)
            begin n_fail++; $display("FAIL addi got %h/%h op %b want 5/ffffffffffffffff op 0010",
                                     input_data1, input_data2, alu_operation); end
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] got[$];
        logic [XLEN+4:0] snap;
        int idx = 0;
        int cyc = 0;
        logic ordy;
        while (got.size() < 4 && cyc < 20) begin
            ordy = (cyc >= 3);
            if (ordy && out_valid) got.push_back(input_data1);
            if (idx < 4 && q.size() < 2) begin
                drive(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 64'(100 + idx), 64'(200 + idx), '0, ordy, 1'b0);
                idx++;
            end else begin
                drive(idx < 4, 2'b10, 3'b000, 1'b0, 1'b0, 64'(100 + idx), 64'(200 + idx), '0, ordy, 1'b0);
            end
            if (cyc == 0) snap = {alu_operation, illegal, input_data1};
            if (cyc == 1 || cyc == 2) begin
                n_tests++;
                if ({alu_operation, illegal, input_data1} !== snap)
                    begin n_fail++; $display("FAIL bp_stable_%0d got %h want %h", cyc,
                                             {alu_operation, illegal, input_data1}, snap); end
            end
            if (cyc == 1) begin
                n_tests++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
            end
            n_tests++;
            if (in_ready !== (q.size() < 2))
                begin n_fail++; $display("FAIL bp_ready_model got %b want %b", in_ready, q.size() < 2); end
            cyc++;
        end
        n_tests++;
        if (got.size() != 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== 64'(100 + i))
                begin n_fail++; $display("FAIL bp_order_%0d got %0d want %0d", i, got[i], 100 + i); end
        end
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        drive_rand(1'b1, 1'b0, 1'b0);
        drive_rand(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full got %b want 0", in_ready); end
        drive(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 64'hDEAD, 64'hBEEF, '0, 1'b0, 1'b1);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL flush_state got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
            n_tests++;
            if (out_valid !== 1'b0)
                begin n_fail++; $display("FAIL flush_ghost_%0d got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive_rand(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0);
            n_tests++;
            if (out_valid !== (q.size() > 0))
                begin n_fail++; $display("FAIL rnd_valid_%0d got %b want %b", c, out_valid, q.size() > 0); end
            n_tests++;
            if (in_ready !== (q.size() < 2))
                begin n_fail++; $display("FAIL rnd_ready_%0d got %b want %b", c, in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                n_tests++;
                if ({alu_operation, illegal, input_data1, input_data2} !== {q[0].op, q[0].ill, q[0].a, q[0].b})
                    begin n_fail++; $display("FAIL rnd_data_%0d got %b/%b/%h/%h want %b/%b/%h/%h", c,
                                             alu_operation, illegal, input_data1, input_data2,
                                             q[0].op, q[0].ill, q[0].a, q[0].b); end
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2'b10, 3'b110, 1'b0, 1'b0, 64'd7, 64'd8, '0, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 3'b001, 1'b0, 1'b0, 64'd9, 64'd6, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL arst_hs got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        n_tests++;
        if (input_data1 !== '0 || input_data2 !== '0 || alu_operation !== 4'b0000 || illegal !== 1'b0)
            begin n_fail++; $display("FAIL arst_data got %h/%h op %b ill %b want zeros",
                                     input_data1, input_data2, alu_operation, illegal); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 64'd11, 64'd12, '0, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || input_data1 !== 64'd11)
            begin n_fail++; $display("FAIL arst_recover got v=%b d1=%0d want v=1 d1=11", out_valid, input_data1); end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        alu_op    = 2'b00;
        funct3    = 3'b000;
        funct7_b5 = 1'b0;
        alu_src   = 1'b0;
        rs1_data  = '0;
        rs2_data  = '0;
        imm       = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_rtype_add();
        test_decode_sweep();
        test_addi();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
